rptr_empty_gen: RTL and testbench
=================================

Name: rptr_empty_gen

Overview:
Parametrised read-side pointer and flag controller for the dual-clock FIFO, successor to the basic gray-pointer empty logic. Adds an internal write-pointer synchronizer of configurable depth, a registered fill-level output and a programmable almost-empty flag. Also generates a RAM read enable and a read-data-valid strobe matched to one-cycle synchronous RAM latency. Sits in the rclk domain between the FIFO dual-port RAM read port and the downstream consumer.

Parameters:
ADDRSIZE, 9, RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
SYNC_STAGES, 2, flops in the wptr gray synchronizer; legal range 2..4.
AEMPTY_THRESH, 4, raempty asserted when fill level <= this value; legal range 0..2**ADDRSIZE-1.

Ports:
rclk  in  1  read-domain clock.
rrst_n  in  1  reset; asynchronous, active-low.
rinc  in  1  read request from consumer.
rwptr_gray  in  ADDRSIZE+1  write pointer, gray code, unsynchronized (write domain).
rptr  out  ADDRSIZE+1  registered gray read pointer, to the write-domain synchronizer.
raddr  out  ADDRSIZE  RAM read address, binary.
ren  out  1  RAM read enable; combinational, = rinc & ~rempty.
rvalid  out  1  read data valid; ren delayed by one rclk.
rempty  out  1  registered empty flag.
raempty  out  1  registered almost-empty flag.
rlevel  out  ADDRSIZE+1  registered fill level in words, 0..2**ADDRSIZE.
runderflow  out  1  sticky underflow flag (RPTR_UNDERFLOW_EN only, else tied 0).
rerr_clr  in  1  synchronous clear of runderflow (ignored without RPTR_UNDERFLOW_EN).

Behaviour:
- Reset (async, rrst_n low): all synchronizer flops 0; rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, rvalid=0, runderflow=0. ren is 0 while rempty=1.
- Synchronizer: rwptr_gray passes through SYNC_STAGES flops; the last stage is wq_gray. No other logic touches the raw input.
- wq_bin = gray-to-binary(wq_gray), combinational XOR-prefix, MSB downward.
- Pointer: rbinnext = rbin + ren; rgraynext = (rbinnext>>1) ^ rbinnext. On each rclk edge rbin<=rbinnext and rptr<=rgraynext. raddr = rbin[ADDRSIZE-1:0].
- Empty: rempty <= (rgraynext == wq_gray). Deasserts SYNC_STAGES+1 rclk edges after rwptr_gray changes. Asserts on the same edge that consumes the last word.
- Level: lvl_next = wq_bin - rbinnext, modulo 2**(ADDRSIZE+1). rlevel<=lvl_next and raempty<=(lvl_next <= AEMPTY_THRESH), both on the same edge as rempty. rempty=1 implies rlevel=0.
- Level is conservative: the stale synchronized wptr can only under-report, never over-report.
- Read latency: raddr is valid with ren in cycle N; RAM data is valid in cycle N+1 with rvalid=1.
- Wrap: the pointer MSB toggles every 2**ADDRSIZE reads; equality and subtraction are modulo, so empty and level stay correct across wrap.
- rinc while rempty=1: ren=0 and pointers hold. This is a legal, non-destructive no-op.
- Simultaneous read of the last word and write arrival: rempty follows rgraynext vs wq_gray only. The new word is seen after synchronization.
- Reset mid-operation: all state returns to reset values immediately. The write side is expected to be reset concurrently.

Optional Feature:
RPTR_UNDERFLOW_EN:
- Defined: runderflow is set on the rclk edge after any cycle with rinc=1 & rempty=1, and holds until rerr_clr=1. If set and clear occur in the same cycle, set wins.
- Undefined: runderflow is tied 0, rerr_clr is unused, and no flop is inferred.

Test Plan:
- Config for all scenarios: ADDRSIZE=4, SYNC_STAGES=2, AEMPTY_THRESH=2.
- Assert rrst_n low for 3 cycles -> rempty=1, raempty=1, rlevel=0, rptr=0, rvalid=0, ren=0 even with rinc=1.
- Set rwptr_gray=0x2 (bin 3) and hold -> rempty=0, rlevel=3, raempty=0 exactly on the 3rd rclk edge; unchanged before that.
- From the previous state, hold rinc=1 for 3 cycles -> ren high 3 cycles, raddr 0,1,2, rvalid high the following 3 cycles. After edge 1: rlevel=2, raempty=1. After edge 3: rempty=1, rlevel=0, rptr=0x2.
- With rempty=1, pulse rinc=1 for 1 cycle -> rptr/raddr unchanged. With RPTR_UNDERFLOW_EN, runderflow=1 next edge, stays set, and clears one edge after rerr_clr=1. Without the macro, runderflow stays 0.
- Advance writes to rwptr_gray=gray(16)=0x18 with rbin=0 -> rlevel=16, raempty=0. Read 16 words -> rempty=1, rptr=0x18, raddr wraps 15->0. Repeat with wptr=gray(32 mod 32)=0 -> correct empty/level across MSB wrap.
- Drop rrst_n mid-burst (rlevel=5) -> all outputs reach reset values asynchronously, before the next rclk edge.

Source files
------------

// File: rtl/rptr_empty_gen_if.sv
// rptr_empty_gen_if: read-side FIFO pointer/flag bundle between consumer/RAM (master) and controller (slave).
interface rptr_empty_gen_if #(parameter int ADDRSIZE = 9);
    logic                rinc;
    logic [ADDRSIZE:0]   rwptr_gray;
    logic                rerr_clr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic                ren;
    logic                rvalid;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;
    modport master (
        output rinc, rwptr_gray, rerr_clr,
        input  rptr, raddr, ren, rvalid, rempty, raempty, rlevel, runderflow
    );
    modport slave (
        input  rinc, rwptr_gray, rerr_clr,
        output rptr, raddr, ren, rvalid, rempty, raempty, rlevel, runderflow
    );
endinterface

// File: rtl/rptr_empty_gen.sv
// rptr_empty_gen: read-domain FIFO pointer, empty/almost-empty/level flags and RAM read strobes.
// Optional sticky underflow flag enabled by defining RPTR_UNDERFLOW_EN.
module rptr_empty_gen #(
    parameter int ADDRSIZE      = 9,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 4
) (
    input logic              rclk,
    input logic              rrst_n,
    rptr_empty_gen_if.slave  bus
);
    localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [SYNC_STAGES-1:0][ADDRSIZE:0] sync_q, sync_d;
    logic [ADDRSIZE:0] rbin_q, rbin_d, rptr_q, rptr_d, rlevel_q, rlevel_d;
    logic [ADDRSIZE:0] wq_gray, wq_bin;
    logic rempty_q, rempty_d, raempty_q, raempty_d, rvalid_q, rvalid_d, ren;

    assign wq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.rwptr_gray};
        ren       = bus.rinc & ~rempty_q;
        rbin_d    = rbin_q + (ADDRSIZE+1)'(ren);
        rptr_d    = (rbin_d >> 1) ^ rbin_d;
        wq_bin    = '0;
        for (int i = 0; i <= ADDRSIZE; i++) wq_bin[i] = ^(wq_gray >> i);
        // Stale synchronized wptr can only make this under-report.
        rlevel_d  = wq_bin - rbin_d;
        rempty_d  = rptr_d == wq_gray;
        raempty_d = rlevel_d <= THRESH;
        rvalid_d  = ren;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sync_q    <= '0;
            rbin_q    <= '0;
            rptr_q    <= '0;
            rlevel_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rlevel_q  <= rlevel_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus.ren     = ren;
    assign bus.rptr    = rptr_q;
    assign bus.raddr   = rbin_q[ADDRSIZE-1:0];
    assign bus.rvalid  = rvalid_q;
    assign bus.rempty  = rempty_q;
    assign bus.raempty = raempty_q;
    assign bus.rlevel  = rlevel_q;

`ifdef RPTR_UNDERFLOW_EN
    logic runderflow_q, runderflow_d;

    // Set has priority over a same-cycle clear.
    always_comb runderflow_d = (bus.rinc & rempty_q) | (runderflow_q & ~bus.rerr_clr);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) runderflow_q <= 1'b0;
        else         runderflow_q <= runderflow_d;
    end

    assign bus.runderflow = runderflow_q;
`else
    logic unused_rerr_clr;
    assign unused_rerr_clr = bus.rerr_clr;
    assign bus.runderflow  = 1'b0;
`endif
endmodule

// File: tb/tb_rptr_empty_gen.sv
// tb_rptr_empty_gen: randomized + directed check of rptr_empty_gen against a count-based FIFO model.
module tb_rptr_empty_gen;
    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    rptr_empty_gen_if #(.ADDRSIZE(4)) bus ();

    rptr_empty_gen #(.ADDRSIZE(4), .SYNC_STAGES(2), .AEMPTY_THRESH(2)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;

    // Model: total words written/read, write count seen through a 2-edge delay.
    int w_tot, r_tot;
    logic [4:0] m_seen0, m_seen1, m_level;
    logic m_empty, m_rvalid, m_uf;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        w_tot = 0; r_tot = 0; m_seen0 = '0; m_seen1 = '0; m_level = '0;
        m_empty = 1'b1; m_rvalid = 1'b0; m_uf = 1'b0;
    endtask

    task automatic chk_outputs();
        logic [4:0] rd;
        rd = 5'(r_tot);
        chk("rptr", 32'(bus.rptr), 32'(gray(rd)));
        chk("raddr", 32'(bus.raddr), 32'(rd[3:0]));
        chk("rempty", 32'(bus.rempty), 32'(m_empty));
        chk("raempty", 32'(bus.raempty), 32'(m_level <= 5'd2));
        chk("rlevel", 32'(bus.rlevel), 32'(m_level));
        chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        chk("runderflow", 32'(bus.runderflow), 32'(m_uf));
    endtask

    task automatic step(input logic inc, input logic clr);
        logic ren_e;
        @(negedge rclk);
        bus.rinc = inc;
        bus.rerr_clr = clr;
        bus.rwptr_gray = gray(5'(w_tot));
        #1;
        ren_e = inc & ~m_empty;
        chk("ren", 32'(bus.ren), 32'(ren_e));
        @(posedge rclk);
        if (ren_e) r_tot++;
        m_level = m_seen1 - 5'(r_tot);
        m_empty = (m_level == 5'd0);
        m_rvalid = ren_e;
`ifdef RPTR_UNDERFLOW_EN
        m_uf = (inc & ~ren_e) | (m_uf & ~clr);
`endif
        m_seen1 = m_seen0;
        m_seen0 = 5'(w_tot);
        #1;
        chk_outputs();
    endtask

    initial begin
        model_reset();
        bus.rinc = 1'b1;
        bus.rerr_clr = 1'b0;
        bus.rwptr_gray = '0;
        repeat (3) @(negedge rclk);
        #1;
        chk("rst_ren", 32'(bus.ren), 32'd0);
        chk_outputs();
        rrst_n = 1'b1;
        bus.rinc = 1'b0;
        // Three words appear after synchronization
        w_tot = 3;
        step(0, 0); step(0, 0);
        chk("pre_sync_empty", 32'(bus.rempty), 32'd1);
        step(0, 0);
        chk("lvl3", 32'(bus.rlevel), 32'd3);
        repeat (3) step(1, 0);
        chk("drain_rptr", 32'(bus.rptr), 32'h2);
        // Reads while empty
        step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
        // Full FIFO and two drains crossing the pointer MSB wrap
        for (int k = 0; k < 2; k++) begin
            w_tot = r_tot + 16;
            repeat (3) step(0, 0);
            chk("full_lvl", 32'(bus.rlevel), 32'd16);
            repeat (16) step(1, 0);
            chk("drained", 32'(bus.rempty), 32'd1);
        end
        // Asynchronous reset mid-burst
        w_tot = r_tot + 8;
        repeat (3) step(0, 0);
        repeat (3) step(1, 0);
        chk("mid_lvl", 32'(bus.rlevel), 32'd5);
        @(negedge rclk);
        bus.rinc = 1'b1;
        #1;
        rrst_n = 1'b0;
        bus.rwptr_gray = '0;
        model_reset();
        #1;
        chk("arst_ren", 32'(bus.ren), 32'd0);
        chk_outputs();
        @(negedge rclk);
        rrst_n = 1'b1;
        // Randomized traffic; writer never exceeds depth 16
        for (int n = 0; n < 400; n++) begin
            if (w_tot - r_tot < 16 && $urandom_range(0, 2) != 0)
                w_tot += $urandom_range(0, (16 - (w_tot - r_tot)) < 3 ? (16 - (w_tot - r_tot)) : 3);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
